// File: rtl/mas_seq_ctrl.sv
// Sequencing controller for the modular add/subtract datapath: latches a job,
// folds a stream of operand beats into a residue mod Q, and hands the result out.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; Q/len latched and job state cleared on accept
// S_ACC  | accepting operand beats, one add/sub + single-step reduction each
// S_DONE | result presented on o_dout until the consumer accepts it
module mas_seq_ctrl #(
   parameter int DW = 5,
   parameter int LW = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic signed [DW-1:0] i_q,
   input  logic        [LW-1:0] i_len,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic signed [DW-1:0] i_din,
   input  logic        [1:0]    i_sel,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic        [3:0]    o_dout,
   output logic        [1:0]    o_tcmp_last,
   output logic                 o_err,
   output logic                 o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic signed [DW:0] r_acc;
   logic signed [DW-1:0] r_q;
   logic [LW-1:0]      r_len;
   logic [LW-1:0]      r_cnt;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_err;
   logic               r_busy;
   logic [1:0]         r_tcmp;
   logic [3:0]         r_dout;

   logic               w_beat;
   logic               w_bad_job;
   logic               w_oor;
   logic [LW-1:0]      w_cnt_inc;
   logic signed [DW:0] w_din_x;
   logic signed [DW:0] w_q_x;
   logic signed [DW:0] w_tmp;
   logic signed [DW:0] w_red;
   logic [1:0]         w_tcmp;

   // One guard bit over DW keeps acc+/-Din exact for any in-range operand.
   assign w_din_x   = {i_din[DW-1], i_din};
   assign w_q_x     = {r_q[DW-1], r_q};
   assign w_beat    = r_in_ready && i_in_valid;
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_bad_job = i_q[DW-1] || (i_q == '0) || (i_len == '0);
   assign w_oor     = i_din[DW-1] || (w_din_x >= w_q_x);

   always_comb begin
      w_tmp = r_acc;
      case (i_sel)
         2'b00:   w_tmp = r_acc + w_din_x;
         2'b11:   w_tmp = r_acc - w_din_x;
         default: w_tmp = r_acc;
      endcase
   end

   always_comb begin
      w_red = w_tmp;
      if (w_tmp[DW]) begin
         w_red = w_tmp + w_q_x;
      end else if (w_tmp >= w_q_x) begin
         w_red = w_tmp - w_q_x;
      end
      w_tcmp = {(w_tmp >= w_q_x), ~w_tmp[DW]};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_q         <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_tcmp      <= 2'b00;
         r_dout      <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_q    <= i_q;
                  r_len  <= i_len;
                  r_acc  <= '0;
                  r_cnt  <= '0;
                  r_tcmp <= 2'b00;
                  r_busy <= 1'b1;
                  if (w_bad_job) begin
                     r_err       <= 1'b1;
                     r_dout      <= 4'd0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_err      <= 1'b0;
                     r_in_ready <= 1'b1;
                     r_state    <= S_ACC;
                  end
               end
            end
            S_ACC: begin
               if (w_beat) begin
                  r_cnt <= w_cnt_inc;
                  // Out-of-range operands still count toward len but leave acc alone.
                  if (w_oor) begin
                     r_err <= 1'b1;
                  end else begin
                     r_acc  <= w_red;
                     r_tcmp <= w_tcmp;
                  end
                  if (w_cnt_inc == r_len) begin
                     r_dout      <= w_oor ? r_acc[3:0] : w_red[3:0];
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_dout      = r_dout;
   assign o_tcmp_last = r_tcmp;
   assign o_err       = r_err;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_mas_seq_ctrl.sv
// Scoreboard bench for mas_seq_ctrl: jobs push hand-computed results, a monitor
// pops and compares them on every output handshake.
module tb_mas_seq_ctrl;

   typedef struct {
      logic [3:0] dout;
      logic [1:0] tcmp;
      logic       err;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_start = 1'b0;
   logic signed [4:0] i_q = '0;
   logic [3:0]        i_len = '0;
   logic              i_in_valid = 1'b0;
   logic              o_in_ready;
   logic signed [4:0] i_din = '0;
   logic [1:0]        i_sel = 2'b00;
   logic              o_out_valid;
   logic              i_out_ready = 1'b1;
   logic [3:0]        o_dout;
   logic [1:0]        o_tcmp_last;
   logic              o_err;
   logic              o_busy;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sb[$];

   mas_seq_ctrl #(.DW(5), .LW(4)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (i_start),
      .i_q         (i_q),
      .i_len       (i_len),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_din       (i_din),
      .i_sel       (i_sel),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_dout      (o_dout),
      .o_tcmp_last (o_tcmp_last),
      .o_err       (o_err),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && o_out_valid && i_out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got dout %0d with no job pending", o_dout);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_dout", int'(o_dout), int'(e.dout));
            chk("sb_tcmp", int'(o_tcmp_last), int'(e.tcmp));
            chk("sb_err",  int'(o_err), int'(e.err));
         end
      end
   end

   function automatic exp_t mk(input int d, input int t, input int e);
      exp_t x;
      x.dout = 4'(d);
      x.tcmp = 2'(t);
      x.err  = 1'(e);
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int q, input int l);
      i_start = 1'b1;
      i_q     = 5'(q);
      i_len   = 4'(l);
      tick();
      i_start = 1'b0;
      i_q     = 5'sd2;
      i_len   = 4'd9;
   endtask

   task automatic send_beat(input logic [1:0] sel, input int din);
      logic taken;
      int   n;
      i_in_valid = 1'b1;
      i_sel      = sel;
      i_din      = 5'(din);
      taken      = 1'b0;
      n          = 0;
      while (!taken && n < 20) begin
         taken = o_in_ready;
         tick();
         n++;
      end
      i_in_valid = 1'b0;
      i_din      = 5'sd13;
      if (!taken) chk("beat_timeout", 0, 1);
   endtask

   task automatic wait_valid(output int waited);
      waited = 0;
      while (!o_out_valid && waited < 40) begin
         tick();
         waited++;
      end
      if (!o_out_valid) chk("out_valid_timeout", 0, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      tick();
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      int t0;
      int w;
      logic [3:0] held;

      #2;
      chk("rst_in_ready",  int'(o_in_ready), 0);
      chk("rst_out_valid", int'(o_out_valid), 0);
      chk("rst_busy",      int'(o_busy), 0);
      chk("rst_err_tcmp",  int'({o_err, o_tcmp_last, o_dout}), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Basic job with latency measurement
      sb.push_back(mk(3, 0, 0));
      t0 = cyc;
      do_start(7, 3);
      chk("acc_in_ready", int'(o_in_ready), 1);
      chk("acc_busy", int'(o_busy), 1);
      send_beat(2'b00, 5);
      send_beat(2'b00, 4);
      send_beat(2'b11, 6);
      wait_valid(w);
      chk("latency", cyc - t0, 4);
      chk("done_in_ready", int'(o_in_ready), 0);
      drain();

      // Pass op, then a wide sum needing the guard bit
      sb.push_back(mk(3, 1, 0));
      do_start(5, 2);
      send_beat(2'b00, 3);
      send_beat(2'b10, 4);
      drain();
      sb.push_back(mk(13, 3, 0));
      do_start(15, 2);
      send_beat(2'b00, 14);
      send_beat(2'b00, 14);
      drain();

      // Out-of-range operand, then err clears on the next clean job
      sb.push_back(mk(2, 1, 1));
      do_start(5, 2);
      send_beat(2'b00, 6);
      send_beat(2'b00, 2);
      drain();
      sb.push_back(mk(2, 0, 0));
      do_start(5, 1);
      send_beat(2'b11, 3);
      drain();

      // Invalid jobs: Q=0 and len=0
      sb.push_back(mk(0, 0, 1));
      i_in_valid = 1'b1;
      do_start(0, 3);
      chk("badq_valid_next", int'(o_out_valid), 1);
      chk("badq_in_ready", int'(o_in_ready), 0);
      i_in_valid = 1'b0;
      drain();
      sb.push_back(mk(0, 0, 1));
      do_start(7, 0);
      chk("badlen_valid_next", int'(o_out_valid), 1);
      chk("badlen_in_ready", int'(o_in_ready), 0);
      drain();

      // Backpressure on both sides
      sb.push_back(mk(3, 0, 0));
      do_start(7, 3);
      send_beat(2'b00, 5);
      tick();
      send_beat(2'b00, 4);
      tick();
      i_out_ready = 1'b0;
      send_beat(2'b11, 6);
      wait_valid(w);
      held = o_dout;
      for (int k = 0; k < 3; k++) begin
         i_start = (k == 1);
         i_q     = 5'sd7;
         i_len   = 4'd1;
         tick();
         chk("bp_valid_hold", int'(o_out_valid), 1);
         chk("bp_dout_hold", int'(o_dout), 3);
      end
      i_start = 1'b0;
      chk("bp_held_start", int'(held), 3);
      i_out_ready = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("bp_idle_after", int'(o_busy), 0);
      chk("bp_no_restart", int'(o_in_ready), 0);
      drain();

      // Reset mid-job
      do_start(7, 3);
      send_beat(2'b00, 5);
      send_beat(2'b00, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", int'(o_in_ready), 0);
      chk("mid_rst_busy", int'(o_busy), 0);
      chk("mid_rst_tcmp", int'(o_tcmp_last), 0);
      chk("mid_rst_valid_err", int'({o_out_valid, o_err}), 0);
      tick();
      rst_n = 1'b1;
      tick();
      sb.push_back(mk(6, 1, 0));
      do_start(7, 1);
      send_beat(2'b00, 6);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got time %0t expected completion", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
